// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit: load, store and
//               writeback-select codes, FSM state enum, byte-enable constants
//               and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // Load type codes (110/111 decode as "no load")
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  // Store type codes
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  // Writeback select: only this code picks load data
  localparam logic [1:0] MTR_LOAD = 2'b01;

  // Byte-enable constants
  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_LO_HW = 4'b0011;
  localparam logic [3:0] BE_HI_HW = 4'b1100;
  localparam logic [3:0] BE_ALL   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_e;

  function automatic logic is_load(input logic [2:0] ld);
    return (ld != LD_NONE) && (ld <= LD_LHU);
  endfunction

  // Stores win over loads when both controls are set, so the store type
  // alone decides alignment in that case.
  function automatic logic is_misaligned(input logic [2:0] ld,
                                         input logic [1:0] st,
                                         input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (st != ST_NONE) begin
      if (st == ST_SH) bad = lo[0];
      if (st == ST_SW) bad = (lo != 2'b00);
    end else begin
      if (ld == LD_LH || ld == LD_LHU) bad = lo[0];
      if (ld == LD_LW)                 bad = (lo != 2'b00);
    end
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic for the LSU.
//               Store side: byte-enable generation and lane replication.
//               Load side : byte/halfword extraction with sign/zero extend.
// Ports       : st_addr_lo/st_type/st_data -> st_be, st_wdata
//               ld_addr_lo/ld_type/ld_rdata -> ld_data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = BE_NONE;
    st_wdata = 32'h0;
    case (st_type)
      ST_SB: begin
        st_be    = BE_BYTE0 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      ST_SH: begin
        st_be    = st_addr_lo[1] ? BE_HI_HW : BE_LO_HW;
        st_wdata = {2{st_data[15:0]}};
      end
      ST_SW: begin
        st_be    = BE_ALL;
        st_wdata = st_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = 8'h0;
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    ld_data = 32'h0;
    case (ld_type)
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LD_LW:   ld_data = ld_rdata;
      LD_LBU:  ld_data = {24'h0, ld_byte};
      LD_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module      : lsu
// Description : Load/store pipeline stage. Accepts the exe2lsu bundle, runs a
//               req/gnt/rvalid handshake to data memory and registers the
//               writeback bundle. lsu_wait stalls execute while busy.
// Ports       : clk, rst (sync, active high); exe2lsu bundle in;
//               dmem_* memory interface; wb_* writeback out; lsu_wait;
//               misalign_err.
// Options     : LSU_MISALIGN_CHECK_EN - drop misaligned half/word accesses
//               and pulse misalign_err instead (tied 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] Rd2_exe2lsu,
  input  logic [1:0]       Memtoreg_exe2lsu,
  input  logic [2:0]       Ld_cntr_exe2lsu,
  input  logic [1:0]       St_cntr_exe2lsu,
  input  logic             RegW_exe2lsu,
  input  logic [4:0]       wr_addr_exe2lsu,
  output logic             lsu_wait,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [3:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_regw,
  output logic [4:0]       wb_addr,
  output logic             misalign_err
);

  state_e            state;
  logic              lat_store;
  logic [2:0]        lat_ld;
  logic [1:0]        lat_mtr;
  logic [WIDTH-1:0]  lat_alu;
  logic              lat_regw;
  logic [4:0]        lat_wr;

  logic              is_store;
  logic              mem_op;
  logic              accept;
  logic [3:0]        st_be;
  logic [WIDTH-1:0]  st_wdata;
  logic [WIDTH-1:0]  ld_data;

  assign is_store = (St_cntr_exe2lsu != ST_NONE);
  assign mem_op   = is_store | is_load(Ld_cntr_exe2lsu);

`ifdef LSU_MISALIGN_CHECK_EN
  logic misaligned;
  logic misalign_q;
  assign misaligned   = mem_op & is_misaligned(Ld_cntr_exe2lsu, St_cntr_exe2lsu,
                                                alu_result[1:0]);
  assign accept       = mem_op & ~misaligned;
  assign misalign_err = misalign_q;
`else
  assign accept       = mem_op;
  assign misalign_err = 1'b0;
`endif

  assign lsu_wait = (state != S_IDLE) | accept;

  // Store lanes come from the live inputs (registered on accept); load
  // extraction uses the latched address/type against returning rdata.
  lsu_align u_align (
    .st_addr_lo (alu_result[1:0]),
    .st_type    (St_cntr_exe2lsu),
    .st_data    (Rd2_exe2lsu),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_addr_lo (lat_alu[1:0]),
    .ld_type    (lat_ld),
    .ld_rdata   (dmem_rdata),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= BE_NONE;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_data    <= '0;
      wb_regw    <= 1'b0;
      wb_addr    <= 5'd0;
      lat_store  <= 1'b0;
      lat_ld     <= LD_NONE;
      lat_mtr    <= 2'b00;
      lat_alu    <= '0;
      lat_regw   <= 1'b0;
      lat_wr     <= 5'd0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      wb_regw <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_store  <= is_store;
            lat_ld     <= Ld_cntr_exe2lsu;
            lat_mtr    <= Memtoreg_exe2lsu;
            lat_alu    <= alu_result;
            lat_regw   <= RegW_exe2lsu;
            lat_wr     <= wr_addr_exe2lsu;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_be    <= is_store ? st_be : BE_ALL;
            dmem_addr  <= {alu_result[WIDTH-1:2], 2'b00};
            dmem_wdata <= is_store ? st_wdata : '0;
            state      <= S_REQ;
`ifdef LSU_MISALIGN_CHECK_EN
          end else if (misaligned) begin
            misalign_q <= 1'b1;
`endif
          end else begin
            wb_data <= alu_result;
            wb_regw <= RegW_exe2lsu;
            wb_addr <= wr_addr_exe2lsu;
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= BE_NONE;
            state    <= lat_store ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            wb_data <= (lat_mtr == MTR_LOAD) ? ld_data : lat_alu;
            wb_regw <= lat_regw;
            wb_addr <= lat_wr;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module      : tb_lsu
// Description : Directed self-checking bench for lsu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu;

  logic        clk;
  logic        rst;
  logic [31:0] alu_result;
  logic [31:0] Rd2_exe2lsu;
  logic [1:0]  Memtoreg_exe2lsu;
  logic [2:0]  Ld_cntr_exe2lsu;
  logic [1:0]  St_cntr_exe2lsu;
  logic        RegW_exe2lsu;
  logic [4:0]  wr_addr_exe2lsu;
  logic        lsu_wait;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data;
  logic        wb_regw;
  logic [4:0]  wb_addr;
  logic        misalign_err;

  int n_cmp = 0;
  int n_bad = 0;

  lsu #(.WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_result       (alu_result),
    .Rd2_exe2lsu      (Rd2_exe2lsu),
    .Memtoreg_exe2lsu (Memtoreg_exe2lsu),
    .Ld_cntr_exe2lsu  (Ld_cntr_exe2lsu),
    .St_cntr_exe2lsu  (St_cntr_exe2lsu),
    .RegW_exe2lsu     (RegW_exe2lsu),
    .wr_addr_exe2lsu  (wr_addr_exe2lsu),
    .lsu_wait         (lsu_wait),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_be          (dmem_be),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_gnt         (dmem_gnt),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .wb_data          (wb_data),
    .wb_regw          (wb_regw),
    .wb_addr          (wb_addr),
    .misalign_err     (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    alu_result       = 32'h0;
    Rd2_exe2lsu      = 32'h0;
    Memtoreg_exe2lsu = 2'b00;
    Ld_cntr_exe2lsu  = 3'b000;
    St_cntr_exe2lsu  = 2'b00;
    RegW_exe2lsu     = 1'b0;
    wr_addr_exe2lsu  = 5'd0;
  endtask

  task automatic set_alu(input logic [31:0] res, input logic [4:0] wr);
    set_nop();
    alu_result      = res;
    RegW_exe2lsu    = 1'b1;
    wr_addr_exe2lsu = wr;
  endtask

  task automatic set_ld(input logic [31:0] addr, input logic [2:0] ld, input logic [4:0] wr);
    set_nop();
    alu_result       = addr;
    Ld_cntr_exe2lsu  = ld;
    Memtoreg_exe2lsu = 2'b01;
    RegW_exe2lsu     = 1'b1;
    wr_addr_exe2lsu  = wr;
  endtask

  task automatic set_st(input logic [31:0] addr, input logic [1:0] st, input logic [31:0] d);
    set_nop();
    alu_result      = addr;
    St_cntr_exe2lsu = st;
    Rd2_exe2lsu     = d;
  endtask

  // Load with gnt in the first REQ cycle and rvalid in the following cycle.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] ld,
                          input logic [4:0] wr, input logic [31:0] rdata,
                          input logic [31:0] exp);
    set_ld(addr, ld, wr);
    #1;
    chk({tag, "_wait_accept"}, {31'h0, lsu_wait}, 32'h1);
    tick();
    set_nop();
    dmem_gnt = 1'b1;
    #1;
    chk({tag, "_req"},   {31'h0, dmem_req}, 32'h1);
    chk({tag, "_we"},    {31'h0, dmem_we}, 32'h0);
    chk({tag, "_addr"},  dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_regw_req"}, {31'h0, wb_regw}, 32'h0);
    chk({tag, "_wait_req"}, {31'h0, lsu_wait}, 32'h1);
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    chk({tag, "_req_drop"}, {31'h0, dmem_req}, 32'h0);
    chk({tag, "_be_drop"},  {28'h0, dmem_be}, 32'h0);
    chk({tag, "_wait_wait"}, {31'h0, lsu_wait}, 32'h1);
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    #1;
    chk({tag, "_wb_data"}, wb_data, exp);
    chk({tag, "_wb_regw"}, {31'h0, wb_regw}, 32'h1);
    chk({tag, "_wb_addr"}, {27'h0, wb_addr}, {27'h0, wr});
    chk({tag, "_wait_done"}, {31'h0, lsu_wait}, 32'h0);
    tick();
    chk({tag, "_regw_pulse"}, {31'h0, wb_regw}, 32'h0);
  endtask

  initial begin
    set_nop();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    rst         = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_req",   {31'h0, dmem_req}, 32'h0);
    chk("rst_be",    {28'h0, dmem_be}, 32'h0);
    chk("rst_addr",  dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_wb",    wb_data, 32'h0);
    chk("rst_regw",  {31'h0, wb_regw}, 32'h0);
    chk("rst_merr",  {31'h0, misalign_err}, 32'h0);
    chk("rst_wait",  {31'h0, lsu_wait}, 32'h0);
    rst = 1'b0;

    // ALU pass-through, back to back
    set_alu(32'h0000_0055, 5'd3);
    #1;
    chk("alu_wait", {31'h0, lsu_wait}, 32'h0);
    tick();
    chk("alu1_data", wb_data, 32'h0000_0055);
    chk("alu1_regw", {31'h0, wb_regw}, 32'h1);
    chk("alu1_addr", {27'h0, wb_addr}, 32'd3);
    set_alu(32'h0000_0066, 5'd4);
    tick();
    chk("alu2_data", wb_data, 32'h0000_0066);
    chk("alu2_addr", {27'h0, wb_addr}, 32'd4);
    set_nop();
    tick();
    chk("alu_nop_regw", {31'h0, wb_regw}, 32'h0);

    // Loads: rdata 0x80AABBCC, byte3 = 0x80, upper half = 0x80AA
    run_load("lw",  32'h0000_0100, 3'b011, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lb",  32'h0000_0103, 3'b001, 5'd6, 32'h80AA_BBCC, 32'hFFFF_FF80);
    run_load("lbu", 32'h0000_0103, 3'b100, 5'd7, 32'h80AA_BBCC, 32'h0000_0080);
    run_load("lh",  32'h0000_0102, 3'b010, 5'd8, 32'h80AA_BBCC, 32'hFFFF_80AA);
    run_load("lhu", 32'h0000_0100, 3'b101, 5'd9, 32'h80AA_BBCC, 32'h0000_BBCC);

    // sh at 0x202
    set_st(32'h0000_0202, 2'b10, 32'h1234_ABCD);
    tick();
    set_nop();
    dmem_gnt = 1'b1;
    #1;
    chk("sh_req",   {31'h0, dmem_req}, 32'h1);
    chk("sh_we",    {31'h0, dmem_we}, 32'h1);
    chk("sh_be",    {28'h0, dmem_be}, 32'h0000_000C);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_addr",  dmem_addr, 32'h0000_0200);
    chk("sh_regw0", {31'h0, wb_regw}, 32'h0);
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("sh_req_drop", {31'h0, dmem_req}, 32'h0);
    chk("sh_we_drop",  {31'h0, dmem_we}, 32'h0);
    chk("sh_regw1",    {31'h0, wb_regw}, 32'h0);
    chk("sh_idle",     {31'h0, lsu_wait}, 32'h0);

    // sb at 0x201
    set_st(32'h0000_0201, 2'b01, 32'h0000_00EF);
    tick();
    set_nop();
    dmem_gnt = 1'b1;
    #1;
    chk("sb_be",    {28'h0, dmem_be}, 32'h0000_0002);
    chk("sb_wdata", dmem_wdata, 32'hEFEF_EFEF);
    tick();
    dmem_gnt = 1'b0;

    // sw with gnt held off for 3 cycles
    set_st(32'h0000_0300, 2'b11, 32'hCAFE_F00D);
    tick();
    set_nop();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sw_hold_req%0d", i), {31'h0, dmem_req}, 32'h1);
      chk($sformatf("sw_hold_addr%0d", i), dmem_addr, 32'h0000_0300);
      chk($sformatf("sw_hold_wdata%0d", i), dmem_wdata, 32'hCAFE_F00D);
      chk($sformatf("sw_hold_be%0d", i), {28'h0, dmem_be}, 32'h0000_000F);
      chk($sformatf("sw_hold_wait%0d", i), {31'h0, lsu_wait}, 32'h1);
      tick();
    end
    dmem_gnt = 1'b1;
    #1;
    chk("sw_gnt_req", {31'h0, dmem_req}, 32'h1);
    tick();
    dmem_gnt = 1'b0;
    set_alu(32'h0000_0077, 5'd10);
    #1;
    chk("sw_after_wait", {31'h0, lsu_wait}, 32'h0);
    chk("sw_after_req",  {31'h0, dmem_req}, 32'h0);
    tick();
    chk("sw_next_alu_data", wb_data, 32'h0000_0077);
    chk("sw_next_alu_regw", {31'h0, wb_regw}, 32'h1);
    set_nop();

    // Reset while in WAIT, then a stray rvalid
    set_ld(32'h0000_0104, 3'b011, 5'd11);
    tick();
    set_nop();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    rst      = 1'b1;
    tick();
    chk("mrst_req",  {31'h0, dmem_req}, 32'h0);
    chk("mrst_addr", dmem_addr, 32'h0);
    chk("mrst_wb",   wb_data, 32'h0);
    chk("mrst_regw", {31'h0, wb_regw}, 32'h0);
    rst         = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    #1;
    chk("mrst_idle_wait", {31'h0, lsu_wait}, 32'h0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("stray_regw", {31'h0, wb_regw}, 32'h0);
    chk("stray_data", wb_data, 32'h0);
    chk("stray_req",  {31'h0, dmem_req}, 32'h0);
    set_alu(32'h0000_0099, 5'd12);
    tick();
    chk("post_rst_alu", wb_data, 32'h0000_0099);
    set_nop();
    tick();

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned lw is dropped with an error pulse
    set_ld(32'h0000_0101, 3'b011, 5'd13);
    #1;
    chk("mis_wait", {31'h0, lsu_wait}, 32'h0);
    tick();
    set_nop();
    #1;
    chk("mis_err",  {31'h0, misalign_err}, 32'h1);
    chk("mis_req",  {31'h0, dmem_req}, 32'h0);
    chk("mis_regw", {31'h0, wb_regw}, 32'h0);
    tick();
    chk("mis_err_pulse", {31'h0, misalign_err}, 32'h0);
    chk("mis_req_after", {31'h0, dmem_req}, 32'h0);
`else
    // Without the check a misaligned lw proceeds on the aligned word
    run_load("lw_mis", 32'h0000_0101, 3'b011, 5'd13, 32'h0BAD_F00D, 32'h0BAD_F00D);
    chk("mis_err_tied", {31'h0, misalign_err}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
